// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle CPU: each microstep is a SETUP cycle followed by a STROBE cycle.
// Build option MEM_TIMEOUT_EN: abort to a sticky FAULT state after 255 unacknowledged memory cycles.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] irContr,
    input  logic       Dcondn,
    input  logic       memAck,
    output logic       rd,
    output logic       TPC,
    output logic       TMAR,
    output logic       RMDRExt,
    output logic       RMDRInt,
    output logic       TMDR2X,
    output logic       TMDR2Ext,
    output logic       T1,
    output logic       wr,
    output logic       LPC,
    output logic       LMAR,
    output logic       LIR,
    output logic       LMDR,
    output logic       LregY,
    output logic       Lflag,
    output logic       LT,
    output logic       TT,
    output logic       TMDR2IR,
    output logic       PCrst,
    output logic [1:0] fnSel,
    output logic [1:0] selreg,
    output logic       memRd,
    output logic       memWr,
    output logic       halted,
    output logic       fault,
    output logic [5:0] dbg_state
);

    typedef enum logic [4:0] {
        ST_RESET, ST_INIT,
        ST_F1, ST_F2, ST_F3, ST_F4,
        ST_E1, ST_E2,
        ST_A1, ST_A2, ST_L3, ST_L4, ST_S3, ST_S4,
        ST_B1, ST_B2,
        ST_HALT, ST_FAULT
    } step_t;

    typedef enum logic {PH_SETUP = 1'b0, PH_STROBE = 1'b1} phase_t;

`ifdef MEM_TIMEOUT_EN
    localparam logic FAULT_OUT = 1'b1;
`else
    localparam logic FAULT_OUT = 1'b0;
`endif

    step_t  step_q, step_d;
    phase_t phase_q, phase_d;
    logic   cond_q, cond_d;
    logic   mem_step;
    logic   strobe;
    logic   timeout;
    logic   unused_ir;

    // The ALU function field is consumed by the datapath, not by the sequencer.
    assign unused_ir = ^irContr[3:0];

    // Memory handshake: memRd/memWr is a request held from SETUP through STROBE; the microstep
    // leaves SETUP only on a clock edge where memAck=1, and the request drops after STROBE.
    assign mem_step = (step_q == ST_F4) || (step_q == ST_L3) || (step_q == ST_S4);
    assign strobe   = (phase_q == PH_STROBE);

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= 8'd0;
        end else if (mem_step && (phase_q == PH_SETUP) && !memAck) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_q <= 8'd0;
        end
    end

    // Fires on the 255th consecutive SETUP cycle without an acknowledge.
    assign timeout = mem_step && (phase_q == PH_SETUP) && !memAck && (wait_cnt_q == 8'd254);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q  <= ST_RESET;
            phase_q <= PH_SETUP;
            cond_q  <= 1'b0;
        end else begin
            step_q  <= step_d;
            phase_q <= phase_d;
            cond_q  <= cond_d;
        end
    end

    always_comb begin
        step_d  = step_q;
        phase_d = phase_q;
        cond_d  = cond_q;
        case (step_q)
            ST_RESET: begin
                step_d  = ST_INIT;
                phase_d = PH_SETUP;
            end
            ST_HALT, ST_FAULT: begin
            end
            default: begin
                if (phase_q == PH_SETUP) begin
                    if (timeout) begin
                        step_d = ST_FAULT;
                    end else if (!mem_step || memAck) begin
                        phase_d = PH_STROBE;
                    end
                    if (step_q == ST_B1) begin
                        cond_d = Dcondn;
                    end
                end else begin
                    phase_d = PH_SETUP;
                    case (step_q)
                        ST_INIT: step_d = ST_F1;
                        ST_F1:   step_d = ST_F2;
                        ST_F2:   step_d = ST_F3;
                        ST_F3:   step_d = ST_F4;
                        ST_F4: begin
                            if (!irContr[6]) begin
                                step_d = ST_E1;
                            end else begin
                                case (irContr[5:4])
                                    2'b00, 2'b01: step_d = ST_A1;
                                    2'b10:        step_d = ST_B1;
                                    default:      step_d = ST_HALT;
                                endcase
                            end
                        end
                        ST_E1:   step_d = ST_E2;
                        ST_A1:   step_d = ST_A2;
                        ST_A2:   step_d = irContr[4] ? ST_S3 : ST_L3;
                        ST_L3:   step_d = ST_L4;
                        ST_S3:   step_d = ST_S4;
                        // An untaken branch skips B2 entirely.
                        ST_B1:   step_d = cond_q ? ST_B2 : ST_F1;
                        default: step_d = ST_F1;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        rd       = 1'b0;
        TPC      = 1'b0;
        TMAR     = 1'b0;
        RMDRExt  = 1'b0;
        RMDRInt  = 1'b0;
        TMDR2X   = 1'b0;
        TMDR2Ext = 1'b0;
        T1       = 1'b0;
        wr       = 1'b0;
        LPC      = 1'b0;
        LMAR     = 1'b0;
        LIR      = 1'b0;
        LMDR     = 1'b0;
        LregY    = 1'b0;
        Lflag    = 1'b0;
        PCrst    = 1'b1;
        fnSel    = 2'b00;
        selreg   = 2'b00;
        memRd    = 1'b0;
        memWr    = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;
        case (step_q)
            ST_RESET, ST_INIT: PCrst = 1'b0;
            ST_F1: begin TPC = 1'b1; fnSel = 2'b01; LMAR = strobe; end
            ST_F2: begin T1 = 1'b1; LregY = strobe; end
            ST_F3: begin TPC = 1'b1; fnSel = 2'b10; LPC = strobe; end
            ST_F4: begin TMAR = 1'b1; memRd = 1'b1; LIR = strobe; end
            ST_E1, ST_A1, ST_B1: begin rd = 1'b1; selreg = 2'b00; LregY = strobe; end
            ST_E2: begin
                rd = 1'b1; selreg = 2'b01; fnSel = 2'b00;
                wr = strobe; Lflag = strobe;
            end
            ST_A2: begin rd = 1'b1; selreg = 2'b01; fnSel = 2'b10; LMAR = strobe; end
            ST_L3: begin TMAR = 1'b1; memRd = 1'b1; RMDRExt = 1'b1; LMDR = strobe; end
            ST_L4: begin TMDR2X = 1'b1; fnSel = 2'b01; wr = strobe; end
            ST_S3: begin
                rd = 1'b1; selreg = 2'b10; fnSel = 2'b01;
                RMDRInt = 1'b1; LMDR = strobe;
            end
            ST_S4: begin TMAR = 1'b1; TMDR2Ext = 1'b1; memWr = 1'b1; end
            ST_B2: begin TPC = 1'b1; fnSel = 2'b10; LPC = strobe; end
            ST_HALT: halted = 1'b1;
            ST_FAULT: fault = FAULT_OUT;
            default: begin
            end
        endcase
    end

    assign LT        = 1'b0;
    assign TT        = 1'b0;
    assign TMDR2IR   = 1'b0;
    assign dbg_state = {phase_q, step_q};

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: table-driven instruction cases, random instruction streams
// checked cycle by cycle against a microprogram reference model, and reset/halt/memory-wait sequences.
module tb_multicycle_controller;

  localparam int W = 27;
  localparam logic [7:0] E_RD = 8'h80, E_TPC = 8'h40, E_TMAR = 8'h20, E_RMDREXT = 8'h10;
  localparam logic [7:0] E_RMDRINT = 8'h08, E_TMDR2X = 8'h04, E_TMDR2EXT = 8'h02, E_T1 = 8'h01;
  localparam logic [6:0] S_WR = 7'h40, S_LPC = 7'h20, S_LMAR = 7'h10, S_LIR = 7'h08;
  localparam logic [6:0] S_LMDR = 7'h04, S_LREGY = 7'h02, S_LFLAG = 7'h01, S_NONE = 7'h00;

  logic       clk, rst;
  logic [6:0] irContr;
  logic       Dcondn, memAck;
  logic       rd, TPC, TMAR, RMDRExt, RMDRInt, TMDR2X, TMDR2Ext, T1;
  logic       wr, LPC, LMAR, LIR, LMDR, LregY, Lflag;
  logic       LT, TT, TMDR2IR, PCrst;
  logic [1:0] fnSel, selreg;
  logic       memRd, memWr, halted, fault;
  logic [5:0] unused_dbg_state;

  int chk_cnt, pass_cnt, cyc;
  int ack_delay, ack_wait;
  int lir_first, wr_first, lflag_first;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [6:0] ir;
    logic       dc;
    int         dly;
    int         lat;
  } vec_t;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .irContr(irContr), .Dcondn(Dcondn), .memAck(memAck),
    .rd(rd), .TPC(TPC), .TMAR(TMAR), .RMDRExt(RMDRExt), .RMDRInt(RMDRInt),
    .TMDR2X(TMDR2X), .TMDR2Ext(TMDR2Ext), .T1(T1),
    .wr(wr), .LPC(LPC), .LMAR(LMAR), .LIR(LIR), .LMDR(LMDR), .LregY(LregY), .Lflag(Lflag),
    .LT(LT), .TT(TT), .TMDR2IR(TMDR2IR), .PCrst(PCrst), .fnSel(fnSel), .selreg(selreg),
    .memRd(memRd), .memWr(memWr), .halted(halted), .fault(fault), .dbg_state(unused_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk(input logic [7:0] ens, input logic [6:0] strb,
                                      input logic pcrst, input logic [1:0] fn, input logic [1:0] sel,
                                      input logic mrd, input logic mwr, input logic hlt, input logic flt);
    return {ens, strb, 3'b000, pcrst, fn, sel, mrd, mwr, hlt, flt};
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {rd, TPC, TMAR, RMDRExt, RMDRInt, TMDR2X, TMDR2Ext, T1,
            wr, LPC, LMAR, LIR, LMDR, LregY, Lflag, LT, TT, TMDR2IR,
            PCrst, fnSel, selreg, memRd, memWr, halted, fault};
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
  endtask

  // reference model: microprogram expanded into per-cycle output vectors
  task automatic push_step(input logic [7:0] ens, input logic [6:0] strb, input logic [1:0] fn,
                           input logic [1:0] sel, input logic mrd, input logic mwr, input int waits);
    for (int i = 0; i <= waits; i++) exp_q.push_back(mk(ens, S_NONE, 1'b1, fn, sel, mrd, mwr, 1'b0, 1'b0));
    exp_q.push_back(mk(ens, strb, 1'b1, fn, sel, mrd, mwr, 1'b0, 1'b0));
  endtask

  task automatic push_fetch(input int dly);
    push_step(E_TPC, S_LMAR, 2'b01, 2'b00, 1'b0, 1'b0, 0);
    push_step(E_T1, S_LREGY, 2'b00, 2'b00, 1'b0, 1'b0, 0);
    push_step(E_TPC, S_LPC, 2'b10, 2'b00, 1'b0, 1'b0, 0);
    push_step(E_TMAR, S_LIR, 2'b00, 2'b00, 1'b1, 1'b0, dly);
  endtask

  task automatic model_instr(input logic [6:0] ir, input logic dc, input int dly);
    push_fetch(dly);
    if (!ir[6]) begin
      push_step(E_RD, S_LREGY, 2'b00, 2'b00, 1'b0, 1'b0, 0);
      push_step(E_RD, S_WR | S_LFLAG, 2'b00, 2'b01, 1'b0, 1'b0, 0);
    end else if (ir[5:4] == 2'b00 || ir[5:4] == 2'b01) begin
      push_step(E_RD, S_LREGY, 2'b00, 2'b00, 1'b0, 1'b0, 0);
      push_step(E_RD, S_LMAR, 2'b10, 2'b01, 1'b0, 1'b0, 0);
      if (ir[5:4] == 2'b00) begin
        push_step(E_TMAR | E_RMDREXT, S_LMDR, 2'b00, 2'b00, 1'b1, 1'b0, dly);
        push_step(E_TMDR2X, S_WR, 2'b01, 2'b00, 1'b0, 1'b0, 0);
      end else begin
        push_step(E_RD | E_RMDRINT, S_LMDR, 2'b01, 2'b10, 1'b0, 1'b0, 0);
        push_step(E_TMAR | E_TMDR2EXT, S_NONE, 2'b00, 2'b00, 1'b0, 1'b1, dly);
      end
    end else if (ir[5:4] == 2'b10) begin
      push_step(E_RD, S_LREGY, 2'b00, 2'b00, 1'b0, 1'b0, 0);
      if (dc) push_step(E_TPC, S_LPC, 2'b10, 2'b00, 1'b0, 1'b0, 0);
    end
  endtask

  // driver: compare the cycle on display, answer memory requests, advance one cycle
  task automatic step_cycle();
    if (exp_q.size() == 0) begin
      chk_cnt++;
      $display("FAIL model_underrun cycle=%0d actual=%h required=none", cyc, dut_vec());
    end else begin
      check("cycle_vec", dut_vec(), exp_q.pop_front());
    end
    check("rd_exclusive", W'(rd & (TPC | T1 | TT | TMDR2X)), '0);
    check("mem_exclusive", W'(memRd & memWr), '0);
    if (LIR && lir_first == 0) lir_first = cyc;
    if (wr && wr_first == 0) wr_first = cyc;
    if (Lflag && lflag_first == 0) lflag_first = cyc;
    if (memRd || memWr) begin
      memAck = (ack_wait >= ack_delay);
      ack_wait++;
    end else begin
      memAck = 1'b0;
      ack_wait = 0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    memAck = 1'b0;
    ack_wait = 0;
    lir_first = 0;
    wr_first = 0;
    lflag_first = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", dut_vec(), '0);
    rst = 1'b0;
    @(negedge clk);
    cyc = 1;
    exp_q.delete();
    repeat (2) exp_q.push_back('0);
    repeat (2) step_cycle();
  endtask

  task automatic run_instr(input logic [6:0] ir, input logic dc, input int dly, input int lat);
    irContr = ir;
    Dcondn = dc;
    ack_delay = dly;
    exp_q.delete();
    model_instr(ir, dc, dly);
    for (int n = 0; n < lat; n++) step_cycle();
    check("return_to_f1", dut_vec(), mk(E_TPC, S_NONE, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.delete();
  endtask

  initial begin
    vec_t tbl[8];
    int   cls, dly, lat;
    logic dc;
    logic [6:0] ir;

    chk_cnt = 0; pass_cnt = 0; cyc = 0;
    rst = 1'b1; irContr = '0; Dcondn = 1'b0; memAck = 1'b0;
    ack_delay = 0; ack_wait = 0;

    tbl[0] = '{7'b0000000, 1'b0, 0, 12};
    tbl[1] = '{7'b0111101, 1'b1, 2, 14};
    tbl[2] = '{7'b1000000, 1'b0, 3, 22};
    tbl[3] = '{7'b1010000, 1'b0, 0, 16};
    tbl[4] = '{7'b1011111, 1'b1, 4, 24};
    tbl[5] = '{7'b1100000, 1'b0, 0, 10};
    tbl[6] = '{7'b1100000, 1'b1, 0, 12};
    tbl[7] = '{7'b1101010, 1'b1, 1, 13};

    // power-up: INIT, then an ALU op with instant acknowledges
    do_reset();
    run_instr(7'b0000000, 1'b0, 0, 12);
    check("lir_cycle", W'(lir_first), W'(10));
    check("wr_cycle", W'(wr_first), W'(14));
    check("lflag_cycle", W'(lflag_first), W'(14));

    for (int i = 0; i < 8; i++) run_instr(tbl[i].ir, tbl[i].dc, tbl[i].dly, tbl[i].lat);

    for (int k = 0; k < 30; k++) begin
      cls = $urandom_range(0, 3);
      dc  = 1'($urandom_range(0, 1));
      dly = $urandom_range(0, 4);
      case (cls)
        0:       ir = {1'b0, 6'($urandom_range(0, 63))};
        1:       ir = {3'b100, 4'($urandom_range(0, 15))};
        2:       ir = {3'b101, 4'($urandom_range(0, 15))};
        default: ir = {3'b110, 4'($urandom_range(0, 15))};
      endcase
      lat = 8 + dly;
      if (cls == 0) lat += 4;
      else if (cls <= 2) lat += 8 + dly;
      else lat += dc ? 4 : 2;
      run_instr(ir, dc, dly, lat);
    end

    // reset asserted while the instruction fetch waits for memory
    do_reset();
    irContr = 7'b0000000;
    ack_delay = 500;
    exp_q.delete();
    push_fetch(500);
    repeat (9) step_cycle();
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", dut_vec(), '0);
    check("async_reset_memrd", W'(memRd), '0);
    do_reset();
    run_instr(7'b0000000, 1'b0, 0, 12);

    // HALT parks the controller
    do_reset();
    irContr = 7'b1110000;
    Dcondn = 1'b0;
    ack_delay = 0;
    exp_q.delete();
    push_fetch(0);
    repeat (50) exp_q.push_back(mk(8'h00, S_NONE, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
    repeat (58) step_cycle();

    // memory never acknowledges
    do_reset();
    irContr = 7'b0000000;
    ack_delay = 100000;
    exp_q.delete();
    push_step(E_TPC, S_LMAR, 2'b01, 2'b00, 1'b0, 1'b0, 0);
    push_step(E_T1, S_LREGY, 2'b00, 2'b00, 1'b0, 1'b0, 0);
    push_step(E_TPC, S_LPC, 2'b10, 2'b00, 1'b0, 1'b0, 0);
`ifdef MEM_TIMEOUT_EN
    repeat (255) exp_q.push_back(mk(E_TMAR, S_NONE, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
    repeat (20) exp_q.push_back(mk(8'h00, S_NONE, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    repeat (281) step_cycle();
    check("timeout_fault", W'(fault), W'(1));
    check("timeout_memrd", W'(memRd), '0);
`else
    repeat (992) exp_q.push_back(mk(E_TMAR, S_NONE, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int n = 0; n < 998; n++) begin
      if (cyc == 1000) begin
        check("wait_memrd_held", W'(memRd), W'(1));
        check("wait_no_fault", W'(fault), '0);
      end
      step_cycle();
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
